// File: rtl/apb_master_bridge.sv
// Bridges the req/gnt/rvalid core protocol onto single APB3 master transfers.
// Optional ACCESS-phase timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter logic [ADDR_W-1:0]  APB_BASE       = 'h1A10_0000,
  parameter logic [ADDR_W-1:0]  APB_END        = 'h1A11_7FFF,
  parameter int unsigned        TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic                pwrite_o,
  output logic                psel_o,
  output logic                penable_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                psel_d, penable_d, rvalid_d, pwrite_d, err_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d, rdata_d;
  logic                in_window;
  logic                fwd_ok;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign in_window = (addr_i >= APB_BASE) && (addr_i <= APB_END);
  assign fwd_ok    = in_window && (!we_i || (&be_i));

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_o;
    penable_d = penable_o;
    rvalid_d  = 1'b0;
    paddr_d   = paddr_o;
    pwdata_d  = pwdata_o;
    pwrite_d  = pwrite_o;
    rdata_d   = rdata_o;
    err_d     = err_o;
    gnt_o     = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          paddr_d  = addr_i;
          pwrite_d = we_i;
          pwdata_d = wdata_i;
          if (fwd_ok) begin
            state_d   = S_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready_i) begin
          state_d   = S_RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = pwrite_o ? '0 : prdata_i;
          err_d     = pslverr_i;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        // Give up on a silent slave; a same-cycle pready above takes priority.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      rvalid_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      psel_o    <= psel_d;
      penable_o <= penable_d;
      rvalid_o  <= rvalid_d;
      paddr_o   <= paddr_d;
      pwdata_o  <= pwdata_d;
      pwrite_o  <= pwrite_d;
      rdata_o   <= rdata_d;
      err_o     <= err_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
